zstr_arb: RTL and testbench

Round-robin arbiter sharing one z stream sink among SN z stream sources. It sits in front of a single consumer such as a stream drain or a downstream block. The arbiter registers a grant and then forwards the granted source's valid, bus and ready unchanged. Grant changes happen only on transfer boundaries, so the sink never sees a stalled transfer switch source.

---
 rtl/zstr_pkg.sv | 35 +++
 rtl/zstr_rr_pick.sv | 22 ++
 rtl/zstr_arb.sv | 100 ++++++++++
 tb/tb_zstr_arb.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zstr_pkg.sv
// Shared types and the rotating-priority search for the zstr_arb slice.
package zstr_pkg;

  localparam int unsigned MAX_SN = 16;
  localparam int unsigned MAX_SW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic              found;
    logic [MAX_SW-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping at sn; ptr is assumed < sn.
  function automatic pick_t rr_pick(input logic [MAX_SN-1:0] req,
                                    input logic [MAX_SW-1:0] ptr,
                                    input int unsigned       sn);
    pick_t      res;
    logic [4:0] j;
    res = '0;
    for (int unsigned k = 0; k < MAX_SN; k++) begin
      j = 5'(ptr) + 5'(k);
      if (j >= 5'(sn)) j = j - 5'(sn);
      if ((k < sn) && !res.found && req[4'(j)]) begin
        res.found = 1'b1;
        res.idx   = 4'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/zstr_rr_pick.sv
// Combinational round-robin priority search with a rotating start index.
module zstr_rr_pick
  import zstr_pkg::*;
#(
  parameter int unsigned SN = 4,
  parameter int unsigned SW = $clog2(SN)
) (
  input  logic [SN-1:0] req,
  input  logic [SW-1:0] ptr,
  output logic          found_c,
  output logic [SW-1:0] idx_c
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_SN'(req), MAX_SW'(ptr), SN);
    found_c = pick.found;
    idx_c   = SW'(pick.idx);
  end

endmodule

// File: rtl/zstr_arb.sv
// Round-robin arbiter sharing one z stream sink among SN sources.
// Define ZSTR_ARB_LOCK_EN to hold the grant for a whole packet (bit BW-1 = last).
module zstr_arb
  import zstr_pkg::*;
#(
  parameter int unsigned     BW = 1,
  parameter logic [BW-1:0]   XZ = 'x,
  parameter int unsigned     SN = 4,
  parameter int unsigned     SW = $clog2(SN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SN-1:0] s_vld,
  input  logic [BW-1:0] s_bus [0:SN-1],
  output logic [SN-1:0] s_rdy,
  output logic          m_vld,
  output logic [BW-1:0] m_bus,
  input  logic          m_rdy,
  output logic [SW-1:0] gnt
);

  state_e        state_q, state_d;
  logic [SW-1:0] gnt_q, gnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
`ifdef ZSTR_ARB_LOCK_EN
  logic          lock_q, lock_d;
`endif

  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          m_trn;
  logic          rel;

  // ptr always sits one past the last grant, so the just-served source is searched last.
  zstr_rr_pick #(
    .SN (SN),
    .SW (SW)
  ) u_pick (
    .req     (s_vld),
    .ptr     (ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef ZSTR_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef ZSTR_ARB_LOCK_EN
      lock_q  <= lock_d;
`endif
    end
  end

  // Forwarding mux for the granted source.
  always_comb begin
    m_vld = 1'b0;
    m_bus = XZ;
    s_rdy = '0;
    if (state_q == BUSY) begin
      m_vld        = s_vld[gnt_q];
      if (s_vld[gnt_q]) m_bus = s_bus[gnt_q];
      s_rdy[gnt_q] = m_rdy;
    end
  end

  assign m_trn = m_vld & m_rdy;
  assign gnt   = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
`ifdef ZSTR_ARB_LOCK_EN
    lock_d  = lock_q;
    if (m_trn) lock_d = ~m_bus[BW-1];
    rel     = m_trn ? m_bus[BW-1] : (~s_vld[gnt_q] & ~lock_q);
`else
    rel     = m_trn | ~s_vld[gnt_q];
`endif
    if ((state_q == IDLE) || rel) begin
      if (pick_found) begin
        state_d = BUSY;
        gnt_d   = pick_idx;
        ptr_d   = (pick_idx == SW'(SN - 1)) ? '0 : pick_idx + SW'(1);
      end else begin
        state_d = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_zstr_arb.sv
// Self-checking bench for zstr_arb: vector table, directed corner sequences, random traffic vs model.
module tb_zstr_arb;

  localparam int unsigned BW = 8;
  localparam int unsigned SN = 4;
  localparam int unsigned SW = 2;
  localparam logic [7:0]  XZ = 8'hE7;
`ifdef ZSTR_ARB_LOCK_EN
  localparam bit         LOCK  = 1'b1;
  localparam logic [7:0] STALL = 8'hDA;
`else
  localparam bit         LOCK  = 1'b0;
  localparam logic [7:0] STALL = 8'h5A;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [SN-1:0] s_vld;
  logic [BW-1:0] s_bus [0:SN-1];
  logic [SN-1:0] s_rdy;
  logic          m_vld;
  logic [BW-1:0] m_bus;
  logic          m_rdy;
  logic [SW-1:0] gnt;

  zstr_arb #(.BW(BW), .XZ(XZ), .SN(SN), .SW(SW)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_vld (s_vld),
    .s_bus (s_bus),
    .s_rdy (s_rdy),
    .m_vld (m_vld),
    .m_bus (m_bus),
    .m_rdy (m_rdy),
    .gnt   (gnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string nm, input bit ev, input logic [7:0] eb,
                         input logic [3:0] er, input int eg);
    cmp({nm, ".m_vld"}, 32'(m_vld), 32'(ev));
    cmp({nm, ".m_bus"}, 32'(m_bus), 32'(eb));
    cmp({nm, ".s_rdy"}, 32'(s_rdy), 32'(er));
    cmp({nm, ".gnt"},   32'(gnt),   32'(eg));
  endtask

  // Reference model: owner is the connected source (-1 = none).
  int mo_owner, mo_gnt, mo_ptr;
  bit mo_lock;

  task automatic model_reset();
    mo_owner = -1; mo_gnt = 0; mo_ptr = 0; mo_lock = 1'b0;
  endtask

  task automatic check_model(input string tag);
    bit ev; logic [7:0] eb; logic [3:0] er; int eg;
    if (mo_owner < 0) begin
      ev = 1'b0; eb = XZ; er = '0; eg = mo_gnt;
    end else begin
      ev = s_vld[mo_owner];
      eb = ev ? s_bus[mo_owner] : XZ;
      er = 4'(m_rdy) << mo_owner;
      eg = mo_owner;
    end
    cmp_out(tag, ev, eb, er, eg);
  endtask

  task automatic model_advance();
    bit trn, last, free;
    free = 1'b1;
    if (mo_owner >= 0) begin
      trn  = s_vld[mo_owner] && m_rdy;
      last = s_bus[mo_owner][7];
      if (LOCK) begin
        if (trn) begin free = last; mo_lock = !last; end
        else free = !s_vld[mo_owner] && !mo_lock;
      end else begin
        free = trn || !s_vld[mo_owner];
      end
    end
    if (free) begin
      mo_owner = -1;
      for (int k = 0; k < SN; k++) begin
        int c;
        c = (mo_ptr + k) % SN;
        if (s_vld[c]) begin
          mo_owner = c; mo_gnt = c; mo_ptr = (c + 1) % SN;
          break;
        end
      end
    end
  endtask

  logic [7:0] srcq [SN][$];

  // One cycle of queue-driven traffic; returns the source that transferred, or -1.
  task automatic traffic_cycle(input bit rdy_in, output int xfer_src);
    @(negedge clk);
    for (int k = 0; k < SN; k++) begin
      s_vld[k] = (srcq[k].size() != 0);
      s_bus[k] = (srcq[k].size() != 0) ? srcq[k][0] : 8'h00;
    end
    m_rdy = rdy_in;
    #1;
    check_model("trf");
    xfer_src = -1;
    if (mo_owner >= 0 && s_vld[mo_owner] && m_rdy) xfer_src = mo_owner;
    model_advance();
    if (xfer_src >= 0) void'(srcq[xfer_src].pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_vld = '0; m_rdy = 1'b0;
    for (int k = 0; k < SN; k++) srcq[k].delete();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] vld;
    bit         rdy;
    bit         e_vld;
    logic [7:0] e_bus;
    logic [3:0] e_rdy;
    int         e_gnt;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    int order[$];
    int exp_ord [4];
    int xs;

    rst = 1'b1; s_vld = '0; m_rdy = 1'b0;
    for (int k = 0; k < SN; k++) s_bus[k] = 8'h00;

    // Reset, fairness (rows 2-9), then idle return (rows 10-13); all beats carry last=1.
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 1'b0, 8'hE7, 4'b0000, 0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 8'hE7, 4'b0000, 0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h80, 4'b0001, 0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h81, 4'b0010, 1};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h82, 4'b0100, 2};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h83, 4'b1000, 3};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h80, 4'b0001, 0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h81, 4'b0010, 1};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h82, 4'b0100, 2};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 8'h83, 4'b1000, 3};
    tbl[10] = '{1'b0, 4'b0010, 1'b1, 1'b0, 8'hE7, 4'b0001, 0};
    tbl[11] = '{1'b0, 4'b0010, 1'b1, 1'b1, 8'h81, 4'b0010, 1};
    tbl[12] = '{1'b0, 4'b0000, 1'b1, 1'b0, 8'hE7, 4'b0010, 1};
    tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 8'hE7, 4'b0000, 1};

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      rst = tbl[i].rst; s_vld = tbl[i].vld; m_rdy = tbl[i].rdy;
      for (int k = 0; k < SN; k++) s_bus[k] = 8'h80 + 8'(k);
      #1;
      cmp_out($sformatf("vec%0d", i), tbl[i].e_vld, tbl[i].e_bus, tbl[i].e_rdy, tbl[i].e_gnt);
    end

    // Stall: source 2 held with m_rdy low, source 0 joins, next grant goes to 0.
    do_reset();
    @(negedge clk);
    s_vld = 4'b0100; s_bus[2] = STALL; s_bus[0] = 8'hC3; m_rdy = 1'b0;
    #1; cmp_out("stall_idle", 1'b0, XZ, 4'b0000, 0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 2) s_vld = 4'b0101;
      #1; cmp_out($sformatf("stall_c%0d", c), 1'b1, STALL, 4'b0000, 2);
    end
    @(negedge clk); m_rdy = 1'b1;
    #1; cmp_out("stall_go", 1'b1, STALL, 4'b0100, 2);
    @(negedge clk); s_vld = 4'b0001;
    #1; cmp_out("stall_next", 1'b1, 8'hC3, 4'b0001, 0);
    @(negedge clk); s_vld = 4'b0000; m_rdy = 1'b0;

    // Wrap: grant 2 leaves ptr=3, then requests {1,2} give 1 then 2.
    do_reset();
    @(negedge clk);
    s_vld = 4'b0100; s_bus[1] = 8'h91; s_bus[2] = 8'h92; m_rdy = 1'b1;
    @(negedge clk); s_vld = 4'b0110;
    #1; cmp_out("wrap_g2", 1'b1, 8'h92, 4'b0100, 2);
    @(negedge clk);
    #1; cmp_out("wrap_g1", 1'b1, 8'h91, 4'b0010, 1);
    @(negedge clk);
    #1; cmp_out("wrap_g2b", 1'b1, 8'h92, 4'b0100, 2);

    // Reset in the middle of an accepted beat drops s_rdy at once.
    do_reset();
    @(negedge clk);
    s_vld = 4'b0001; s_bus[0] = 8'h81; m_rdy = 1'b1;
    @(negedge clk);
    #1; cmp("mid_rst.pre_s_rdy", 32'(s_rdy), 32'h1);
    #1; rst = 1'b1;
    #1; cmp_out("mid_rst", 1'b0, XZ, 4'b0000, 0);

    // Packet lock: source 0 sends 3 beats while source 1 keeps requesting.
    do_reset();
    srcq[0].push_back(8'h01); srcq[0].push_back(8'h02); srcq[0].push_back(8'h83);
    srcq[1].push_back(8'hB1); srcq[1].push_back(8'hB1);
    if (LOCK) exp_ord = '{0, 0, 0, 1};
    else      exp_ord = '{0, 1, 0, 1};
    for (int c = 0; c < 12; c++) begin
      traffic_cycle(1'b1, xs);
      if (xs >= 0) order.push_back(xs);
    end
    for (int b = 0; b < 4; b++) begin
      if (b < order.size()) cmp($sformatf("lock_order%0d", b), 32'(order[b]), 32'(exp_ord[b]));
      else                  cmp($sformatf("lock_order%0d_missing", b), 32'hFFFF_FFFF, 32'(exp_ord[b]));
    end

    // Random packet traffic against the model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < SN; k++) begin
        if (srcq[k].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          len = int'($urandom_range(3, 1));
          for (int b = 0; b < len; b++)
            srcq[k].push_back({(b == len - 1) ? 1'b1 : 1'b0, 7'($urandom)});
        end
      end
      traffic_cycle($urandom_range(3) != 0, xs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
